// File: rtl/fifo_uart_drain_pkg.sv
// rtl/fifo_uart_drain_pkg.sv - shared FSM encoding and baud-period derivation for the UART drain
package fifo_uart_drain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    // Clock cycles per UART symbol; also used by the matching receiver.
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/fifo_uart_drain_baud_tick.sv
// rtl/fifo_uart_drain_baud_tick.sv - symbol-period counter with clear and one-cycle terminal tick
module uart_baud_tick #(
    parameter int SYMBOL_EDGE_TIME = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] TOP = CW'(SYMBOL_EDGE_TIME - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == TOP);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_drain.sv
// rtl/fifo_uart_drain.sv - pops bytes from a one-cycle-latency FIFO and sends them as 8N1 UART frames
module fifo_uart_drain
    import fifo_uart_drain_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_enable,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             serial_out,
    output logic             busy
);

    localparam int SET   = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int BIT_W = $clog2(WIDTH + 2);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH + 1);

    state_t           state, state_next;
    logic [WIDTH+1:0] shift, shift_next;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_next;
    logic             tick, baud_clr, baud_en;

    uart_baud_tick #(.SYMBOL_EDGE_TIME(SET)) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .en   (baud_en),
        .tick (tick)
    );

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        fifo_rd_en   = 1'b0;
        baud_clr     = 1'b0;
        baud_en      = 1'b0;
        case (state)
            IDLE: begin
                fifo_rd_en = !rst && tx_enable && !fifo_empty;
                if (fifo_rd_en) state_next = LOAD;
            end
            LOAD: begin
                // fifo_dout is valid only now, the cycle after the pop
                shift_next   = {1'b1, fifo_dout, 1'b0};
                bit_cnt_next = '0;
                baud_clr     = 1'b1;
                state_next   = SEND;
            end
            SEND: begin
                baud_en = 1'b1;
                if (tick) begin
                    shift_next = {1'b1, shift[WIDTH+1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '1;
            bit_cnt    <= '0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_cnt    <= bit_cnt_next;
            // Registered line tracks shift[0] while sending, high otherwise
            serial_out <= (state_next == SEND) ? shift_next[0] : 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb/tb_fifo_uart_drain.sv - scoreboard bench: FIFO model, UART line decoder, directed scenarios
module tb_fifo_uart_drain;

    localparam int SET = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout = 8'h00;
    logic       serial_out;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         starts_q[$];
    int         cyc = 0;
    int         pop_count = 0;
    int         pop_empty = 0;
    int         frames = 0;
    int         busy_run = 0;
    int         busy_last = 0;
    logic       pop_pending = 1'b0;

    fifo_uart_drain #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_enable  (tx_enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .serial_out (serial_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // FIFO model: dout carries data only in the cycle after a pop, zero otherwise
    always @(negedge clk) begin
        pop_pending = fifo_rd_en;
        if (fifo_rd_en) begin
            pop_count++;
            if (fifo_empty) pop_empty++;
        end
        if (busy) busy_run++;
        else if (busy_run > 0) begin
            busy_last = busy_run;
            busy_run  = 0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (pop_pending && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
            else fifo_dout = 8'h00;
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Line monitor: captures a whole frame from the falling start edge, aborting on reset
    initial begin
        logic       samp[100];
        logic       aborted, stable;
        logic [7:0] data;
        int         start;
        forever begin
            @(negedge clk);
            if (serial_out === 1'b0 && !rst) begin
                start   = cyc;
                aborted = 1'b0;
                samp[0] = 1'b0;
                for (int i = 1; i < 100; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp[i] = serial_out;
                end
                if (!aborted) begin
                    stable = 1'b1;
                    for (int k = 0; k < 10; k++)
                        for (int j = 0; j < 10; j++)
                            if (samp[k*10+j] !== samp[k*10]) stable = 1'b0;
                    for (int k = 0; k < 8; k++) data[k] = samp[(k+1)*10];
                    starts_q.push_back(start);
                    check("bit_stable", {31'd0, stable}, 32'd1);
                    check("stop_bit", {31'd0, samp[90]}, 32'd1);
                    if (exp_q.size() == 0) check("unexpected_frame", {24'd0, data}, 32'hFFFF_FFFF);
                    else check("frame_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
                    frames++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b, input logic expect_tx);
        fifo_q.push_back(b);
        if (expect_tx) exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int target, input string name);
        int n = 0;
        while (frames < target && n < 2000) begin
            step(1);
            n++;
        end
        check({name, "_timeout"}, {31'd0, frames >= target}, 32'd1);
        step(2);
    endtask

    task automatic wait_pops(input int target, input string name);
        int n = 0;
        while (pop_count < target && n < 500) begin
            step(1);
            n++;
        end
        check({name, "_pop_timeout"}, {31'd0, pop_count >= target}, 32'd1);
    endtask

    initial begin
        int p0, f0;
        logic ok;
        step(3);
        rst = 1'b0;
        step(1);
        check("reset_serial_out", {31'd0, serial_out}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);

        // single byte
        tx_enable = 1'b1;
        push(8'hA5, 1'b1);
        wait_frames(1, "single");
        step(3);
        check("single_pops", pop_count, 32'd1);
        check("single_busy_len", busy_last, 32'd101);

        // burst: 2-cycle high gap after each stop bit gives 102-cycle start spacing
        starts_q.delete();
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        push(8'h3C, 1'b1);
        wait_frames(4, "burst");
        check("burst_frames", starts_q.size(), 32'd3);
        if (starts_q.size() == 3) begin
            check("burst_gap01", starts_q[1] - starts_q[0], 32'd102);
            check("burst_gap12", starts_q[2] - starts_q[1], 32'd102);
        end
        check("burst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
        check("burst_pops", pop_count, 32'd4);

        // empty for 200 cycles
        ok = 1'b1;
        repeat (200) begin
            step(1);
            if (fifo_rd_en !== 1'b0 || serial_out !== 1'b1) ok = 1'b0;
        end
        check("empty_quiet", {31'd0, ok}, 32'd1);

        // disabled with data present
        tx_enable = 1'b0;
        p0 = pop_count;
        push(8'h55, 1'b1);
        step(100);
        check("disabled_no_pop", pop_count, p0);
        tx_enable = 1'b1;
        wait_frames(5, "disabled_release");

        // enable drop during data bit 3 of 0x81
        p0 = pop_count;
        push(8'h81, 1'b1);
        push(8'h42, 1'b1);
        wait_pops(p0 + 1, "drop");
        step(45);
        tx_enable = 1'b0;
        wait_frames(6, "drop_finish");
        step(200);
        check("drop_no_pop", pop_count, p0 + 1);
        check("drop_idle", {31'd0, busy}, 32'd0);
        tx_enable = 1'b1;
        wait_frames(7, "drop_resume");

        // reset during data bit 5: 0xC3 discarded, 0x5A follows
        p0 = pop_count;
        f0 = frames;
        push(8'hC3, 1'b0);
        push(8'h5A, 1'b1);
        wait_pops(p0 + 1, "rst");
        step(64);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_serial_out", {31'd0, serial_out}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        wait_frames(f0 + 1, "rst_next");

        step(20);
        check("pop_while_empty", pop_empty, 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("fifo_drained", fifo_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
